window_gen: RTL and testbench

WINDOW_GEN -- requirements
Module: window_gen

---
 rtl/window_pkg.sv | 20 ++
 rtl/window_index_gen.sv | 84 ++++++++
 rtl/window_gen.sv | 122 ++++++++++++
 tb/tb_window_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/window_pkg.sv
// Shared types and constants for the window generator: shape encoding,
// control FSM states and the arithmetic pipeline depth.
package window_pkg;

  typedef enum logic [1:0] {
    MODE_RECT   = 2'd0,
    MODE_TRI    = 2'd1,
    MODE_PARZEN = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam int STAGES = 4;

endpackage

// File: rtl/window_index_gen.sv
// Run control for the window generator: IDLE/RUN/DRAIN FSM, sample index
// counter, frame counting and the sticky stop request.
module window_index_gen
  import window_pkg::*;
#(
  parameter int WINDOW_SIZE_POW2 = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stop,
  input  logic [1:0]                  mode,
  input  logic [15:0]                 frames,
  input  logic                        advance,
  input  logic                        last_hs,
  output logic [WINDOW_SIZE_POW2-1:0] idx,
  output logic                        idx_valid,
  output logic                        idx_last,
  output mode_e                       run_mode,
  output logic                        busy,
  output logic                        done
);

  localparam logic [WINDOW_SIZE_POW2-1:0] LAST_IDX = '1;

  state_e      state, next_state;
  logic [15:0] frame_cnt;
  logic [15:0] frames_q;
  logic        stop_q;
  logic        final_window;

  // Stop seen in the current cycle counts too, so a stop on the last beat still ends the run.
  assign final_window = stop_q || stop ||
                        ((frames_q != 16'd0) && (frame_cnt == frames_q - 16'd1));
  assign idx_valid    = (state == S_RUN);
  assign idx_last     = (idx == LAST_IDX);
  assign busy         = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_RUN;
      S_RUN:   if (advance && idx_last && final_window) next_state = S_DRAIN;
      S_DRAIN: if (last_hs) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      frame_cnt <= '0;
      frames_q  <= '0;
      stop_q    <= 1'b0;
      run_mode  <= MODE_RECT;
      done      <= 1'b0;
    end else begin
      done <= (state == S_DRAIN) && last_hs;
      case (state)
        S_IDLE: if (start) begin
          idx       <= '0;
          frame_cnt <= '0;
          frames_q  <= frames;
          stop_q    <= stop;
          run_mode  <= (mode_e'(mode) == MODE_RSVD) ? MODE_RECT : mode_e'(mode);
        end
        S_RUN: begin
          if (stop) stop_q <= 1'b1;
          if (advance) begin
            idx <= idx + 1'b1;
            if (idx_last) frame_cnt <= frame_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/window_gen.sv
// Window coefficient generator: index control plus a four-stage fixed-point
// pipeline producing rectangular, triangular or Parzen samples.
module window_gen
  import window_pkg::*;
#(
  parameter int WINDOW_SIZE_POW2 = 10,
  parameter int INTERNAL_FRAC    = 16,
  parameter int OUTPUT_INT       = 1,
  parameter int OUTPUT_FRAC      = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [1:0]                        mode,
  input  logic [15:0]                       frames,
  input  logic                              start,
  input  logic                              stop,
  output logic                              busy,
  output logic                              done,
  input  logic                              window_out_ready,
  output logic [OUTPUT_INT+OUTPUT_FRAC-1:0] window_out,
  output logic                              window_out_valid,
  output logic                              window_out_last
);

  localparam int P   = WINDOW_SIZE_POW2;
  localparam int F   = INTERNAL_FRAC;
  localparam int OW  = OUTPUT_INT + OUTPUT_FRAC;
  localparam int W3  = 3 * F + 4;
  localparam int WS  = W3 + OW;
  localparam int SHR = (3 * F > OUTPUT_FRAC) ? 3 * F - OUTPUT_FRAC : 0;
  localparam int SHL = (OUTPUT_FRAC > 3 * F) ? OUTPUT_FRAC - 3 * F : 0;

  localparam logic [P-1:0]  HALF_N = {1'b1, {(P-1){1'b0}}};
  localparam logic [F:0]    ONE_F  = {1'b1, {F{1'b0}}};
  localparam logic [F:0]    HALF_F = {2'b01, {(F-1){1'b0}}};
  localparam logic [W3-1:0] ONE_3F = {{(W3-3*F-1){1'b0}}, 1'b1, {(3*F){1'b0}}};
  localparam logic [W3-1:0] SIX    = W3'(6);
  localparam logic [WS-1:0] OMAX   = {{(WS-OW){1'b0}}, {OW{1'b1}}};

  if (INTERNAL_FRAC < WINDOW_SIZE_POW2 - 1) begin : g_frac_chk
    $error("INTERNAL_FRAC must be at least WINDOW_SIZE_POW2-1");
  end
  if (OUTPUT_INT < 1) begin : g_int_chk
    $error("OUTPUT_INT must be at least 1");
  end
  if (WINDOW_SIZE_POW2 < 2 || WINDOW_SIZE_POW2 > 16) begin : g_pow_chk
    $error("WINDOW_SIZE_POW2 must lie in 2..16");
  end

  logic [P-1:0]      idx;
  logic              idx_valid, idx_last;
  mode_e             run_mode;
  logic              en, last_hs;
  logic [STAGES-1:0] vld, lst;

  logic [P-1:0]      diff;
  logic [F:0]        b1, b2, om2;
  logic [2*F+1:0]    bsq2, omsq2;
  logic [3*F+2:0]    bcube, omcube;
  logic [W3-1:0]     res_c, res3;
  logic [WS-1:0]     scaled, sat;

  // The whole pipeline freezes only when the output holds an unaccepted sample.
  assign en      = !vld[STAGES-1] || window_out_ready;
  assign last_hs = window_out_valid && window_out_ready && window_out_last;

  window_index_gen #(.WINDOW_SIZE_POW2(P)) u_index (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .frames    (frames),
    .advance   (en),
    .last_hs   (last_hs),
    .idx       (idx),
    .idx_valid (idx_valid),
    .idx_last  (idx_last),
    .run_mode  (run_mode),
    .busy      (busy),
    .done      (done)
  );

  assign diff = (idx >= HALF_N) ? idx - HALF_N : HALF_N - idx;

  // Parzen uses the cubic near the centre and 2(1-b)^3 on the tails; all terms carry 3F fraction bits.
  always_comb begin
    bcube  = bsq2 * b2;
    omcube = omsq2 * om2;
    res_c  = ONE_3F;
    case (run_mode)
      MODE_TRI:    res_c = W3'(om2) << (2 * F);
      MODE_PARZEN: res_c = (b2 > HALF_F) ? (W3'(omcube) << 1)
                         : ONE_3F + SIX * W3'(bcube) - SIX * (W3'(bsq2) << F);
      default:     res_c = ONE_3F;
    endcase
    scaled = (WS'(res3) >> SHR) << SHL;
    sat    = (scaled > OMAX) ? OMAX : scaled;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0; lst <= '0;
      b1 <= '0; b2 <= '0; om2 <= '0; bsq2 <= '0; omsq2 <= '0; res3 <= '0;
      window_out <= '0;
    end else if (en) begin
      vld   <= {vld[STAGES-2:0], idx_valid};
      lst   <= {lst[STAGES-2:0], idx_valid && idx_last};
      b1    <= (F+1)'(diff) << (F - P + 1);
      b2    <= b1;
      om2   <= ONE_F - b1;
      bsq2  <= b1 * b1;
      omsq2 <= (ONE_F - b1) * (ONE_F - b1);
      res3  <= res_c;
      window_out <= vld[STAGES-2] ? sat[OW-1:0] : '0;
    end
  end

  assign window_out_valid = vld[STAGES-1];
  assign window_out_last  = lst[STAGES-1];

endmodule

// File: tb/tb_window_gen.sv
// Scoreboard bench for window_gen with N=16: stimulus queues hand-computed
// samples, a negedge monitor pops and compares on every handshake.
module tb_window_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [15:0] frames = 16'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        busy, done;
  logic        window_out_ready = 1'b1;
  logic [16:0] window_out;
  logic        window_out_valid, window_out_last;

  typedef struct {
    logic [16:0] data;
    logic        last;
    logic        fin;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   beat_cnt = 0;
  bit   done_pending = 0;

  logic [16:0] parzen_tab [16] = '{17'h00000, 17'h00100, 17'h00800, 17'h01B00,
                                   17'h04000, 17'h07900, 17'h0B800, 17'h0EB00,
                                   17'h10000, 17'h0EB00, 17'h0B800, 17'h07900,
                                   17'h04000, 17'h01B00, 17'h00800, 17'h00100};
  logic [16:0] tri_tab [16]    = '{17'h00000, 17'h02000, 17'h04000, 17'h06000,
                                   17'h08000, 17'h0A000, 17'h0C000, 17'h0E000,
                                   17'h10000, 17'h0E000, 17'h0C000, 17'h0A000,
                                   17'h08000, 17'h06000, 17'h04000, 17'h02000};

  window_gen #(
    .WINDOW_SIZE_POW2(4), .INTERNAL_FRAC(16), .OUTPUT_INT(1), .OUTPUT_FRAC(16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .mode             (mode),
    .frames           (frames),
    .start            (start),
    .stop             (stop),
    .busy             (busy),
    .done             (done),
    .window_out_ready (window_out_ready),
    .window_out       (window_out),
    .window_out_valid (window_out_valid),
    .window_out_last  (window_out_last)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_window(input int shape, input bit fin);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.data = (shape == 2) ? parzen_tab[i] : (shape == 1) ? tri_tab[i] : 17'h10000;
      e.last = (i == 15);
      e.fin  = fin && (i == 15);
      q.push_back(e);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] m, input logic [15:0] f, input logic s);
    beat_cnt = 0;
    mode = m; frames = f; stop = s; start = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int guard = 0;
    while (beat_cnt < n && guard < 500) begin tick(); guard++; end
    if (beat_cnt < n) check_output("beat_timeout", beat_cnt, n);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((busy || q.size() != 0 || done_pending) && guard < 500) begin tick(); guard++; end
    if (guard >= 500) begin
      check_output("idle_timeout", q.size(), 0);
      q.delete();
    end
    tick(); tick();
  endtask

  // Monitor: compare every accepted sample against the queue head and check the done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      done_pending = 0;
    end else begin
      if (done || done_pending) check_output("done", done, done_pending);
      done_pending = 0;
      if (!window_out_valid) begin
        if (window_out !== 17'h0) check_output("out_zero_when_invalid", window_out, 0);
      end else if (window_out_ready) begin
        if (q.size() == 0) begin
          check_output("unexpected_sample", window_out, 32'hDEAD);
        end else begin
          e = q.pop_front();
          check_output($sformatf("sample[%0d]", beat_cnt), window_out, e.data);
          check_output($sformatf("last[%0d]", beat_cnt), window_out_last, e.last);
          beat_cnt++;
          if (e.fin) done_pending = 1;
        end
      end
    end
  end

  initial begin
    logic [16:0] snap_out;
    logic        snap_last;

    repeat (3) tick();
    check_output("rst_valid", window_out_valid, 0);
    check_output("rst_last", window_out_last, 0);
    check_output("rst_out", window_out, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    rst = 1'b0;
    tick();

    $display("[TB] Parzen single window with latency check");
    push_window(2, 1);
    apply_stimulus(2'd2, 16'd1, 1'b0);
    check_output("busy_after_start", busy, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("latency_no_valid", window_out_valid, 0);
    end
    tick();
    check_output("latency_valid", window_out_valid, 1);
    wait_idle();
    check_output("busy_after_done", busy, 0);

    $display("[TB] Triangular and rectangular windows");
    push_window(1, 1);
    apply_stimulus(2'd1, 16'd1, 1'b0);
    wait_idle();
    push_window(0, 1);
    apply_stimulus(2'd0, 16'd1, 1'b0);
    wait_idle();

    $display("[TB] Parzen with a 5-cycle stall at beat 6");
    push_window(2, 1);
    apply_stimulus(2'd2, 16'd1, 1'b0);
    wait_beats(6);
    window_out_ready = 1'b0;
    snap_out  = window_out;
    snap_last = window_out_last;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("stall_valid", window_out_valid, 1);
      check_output("stall_out", window_out, snap_out);
      check_output("stall_last", window_out_last, snap_last);
    end
    check_output("stall_beats_held", beat_cnt, 6);
    window_out_ready = 1'b1;
    wait_idle();

    $display("[TB] Two frames with ignored restart");
    push_window(2, 0);
    push_window(2, 1);
    apply_stimulus(2'd2, 16'd2, 1'b0);
    for (int guard = 0; q.size() != 0 && guard < 200; guard++) begin
      if (beat_cnt == 10) begin
        mode = 2'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      check_output("busy_during_run", busy, 1);
      tick();
    end
    start = 1'b0;
    wait_idle();

    $display("[TB] Continuous run stopped at beat 20");
    push_window(1, 0);
    push_window(1, 1);
    apply_stimulus(2'd1, 16'd0, 1'b0);
    wait_beats(20);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_idle();
    check_output("stop_total_beats", beat_cnt, 32);

    $display("[TB] Start with stop in the same cycle, reserved mode");
    push_window(0, 1);
    apply_stimulus(2'd3, 16'd0, 1'b1);
    wait_idle();
    check_output("one_window_beats", beat_cnt, 16);

    $display("[TB] Reset at beat 7 then restart");
    push_window(2, 1);
    apply_stimulus(2'd2, 16'd1, 1'b0);
    wait_beats(7);
    rst = 1'b1;
    q.delete();
    tick();
    check_output("midrst_valid", window_out_valid, 0);
    check_output("midrst_last", window_out_last, 0);
    check_output("midrst_out", window_out, 0);
    check_output("midrst_busy", busy, 0);
    check_output("midrst_done", done, 0);
    rst = 1'b0;
    tick();
    push_window(2, 1);
    apply_stimulus(2'd2, 16'd1, 1'b0);
    wait_idle();
    check_output("restart_beats", beat_cnt, 16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
